// File: rtl/flow_led_if.sv
// flow_led_if: LED ring sample bus, soft-clear input and monitor status outputs.
// The monitor uses the slave modport; the generator/bench side uses master.
interface flow_led_if #(
    parameter int LED_NUM = 4,
    parameter int LAP_W   = 16,
    parameter int ERR_W   = 8
);
    localparam int POS_W = $clog2(LED_NUM);

    logic [LED_NUM-1:0] led_in;
    logic               clr_err;
    logic               locked;
    logic [POS_W-1:0]   pos;
    logic [LAP_W-1:0]   lap;
    logic               err;
    logic               fault;
    logic [ERR_W-1:0]   err_count;

    modport master (
        output led_in, clr_err,
        input  locked, pos, lap, err, fault, err_count
    );

    modport slave (
        input  led_in, clr_err,
        output locked, pos, lap, err, fault, err_count
    );
endinterface

// File: rtl/flow_led_monitor.sv
// flow_led_monitor: verifies a rotating one-hot LED ring, tracking lock, position, laps and errors.
// Define FLOW_LED_MON_STALL_EN to accept a repeated valid sample as a legal stall.
module flow_led_monitor #(
    parameter int LED_NUM     = 4,
    parameter int LOCK_CYCLES = 3,
    parameter int LAP_W       = 16,
    parameter int ERR_W       = 8
) (
    input  logic      clk,
    input  logic      rst,
    flow_led_if.slave bus
);
    localparam int POS_W = $clog2(LED_NUM);
`ifdef FLOW_LED_MON_STALL_EN
    localparam logic STALL_EN = 1'b1;
`else
    localparam logic STALL_EN = 1'b0;
`endif
    localparam logic [7:0]       GOOD_LAST = 8'(LOCK_CYCLES - 1);
    localparam logic [7:0]       GOOD_ONE  = 8'd1;
    localparam logic [LAP_W-1:0] LAP_ONE   = {{(LAP_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [LED_NUM-1:0] v);
        logic [LED_NUM-1:0] one;
        one = {{(LED_NUM-1){1'b0}}, 1'b1};
        return (v != {LED_NUM{1'b0}}) && ((v & (v - one)) == {LED_NUM{1'b0}});
    endfunction

    function automatic logic [POS_W-1:0] index_of(input logic [LED_NUM-1:0] v);
        logic [POS_W-1:0] r;
        r = {POS_W{1'b0}};
        for (int i = 0; i < LED_NUM; i++) begin
            if (v[i]) r = POS_W'(i);
            else      r = r;
        end
        return r;
    endfunction

    state_t             state_r, state_s;
    logic [LED_NUM-1:0] prev_r;
    logic [7:0]         good_r, good_s;
    logic               locked_r, locked_s;
    logic [POS_W-1:0]   pos_r, pos_s;
    logic [LAP_W-1:0]   lap_r, lap_s;
    logic               err_r, err_s;
    logic               fault_r, fault_s;
    logic [ERR_W-1:0]   errc_r, errc_s;
    logic               valid_s, match_s, stall_s;
    logic [LED_NUM-1:0] expect_s;

    assign bus.locked    = locked_r;
    assign bus.pos       = pos_r;
    assign bus.lap       = lap_r;
    assign bus.err       = err_r;
    assign bus.fault     = fault_r;
    assign bus.err_count = errc_r;

    // Next-state and next-output decode; clear is applied first so a same-cycle violation wins.
    always_comb begin
        valid_s  = is_onehot(bus.led_in);
        expect_s = {prev_r[LED_NUM-2:0], prev_r[LED_NUM-1]};
        match_s  = (bus.led_in == expect_s);
        stall_s  = STALL_EN && valid_s && (bus.led_in == prev_r);

        state_s  = state_r;
        good_s   = good_r;
        locked_s = locked_r;
        pos_s    = pos_r;
        lap_s    = lap_r;
        err_s    = 1'b0;
        fault_s  = fault_r;
        errc_s   = errc_r;

        if (bus.clr_err) begin
            fault_s = 1'b0;
            errc_s  = {ERR_W{1'b0}};
            lap_s   = {LAP_W{1'b0}};
        end else begin
            fault_s = fault_r;
        end

        case (state_r)
            HUNT: begin
                if (valid_s) begin
                    state_s = ACQ;
                    good_s  = 8'd0;
                end else begin
                    state_s = HUNT;
                end
            end
            ACQ: begin
                if (stall_s) begin
                    state_s = ACQ;
                end else if (match_s) begin
                    if (good_r == GOOD_LAST) begin
                        state_s  = LOCKED;
                        locked_s = 1'b1;
                        pos_s    = index_of(bus.led_in);
                        good_s   = 8'd0;
                    end else begin
                        good_s = good_r + GOOD_ONE;
                    end
                end else if (valid_s) begin
                    good_s = 8'd0;
                end else begin
                    state_s = HUNT;
                    good_s  = 8'd0;
                end
            end
            LOCKED: begin
                if (stall_s) begin
                    state_s = LOCKED;
                end else if (match_s) begin
                    pos_s = index_of(bus.led_in);
                    if (prev_r[LED_NUM-1] && bus.led_in[0]) lap_s = lap_s + LAP_ONE;
                    else                                    lap_s = lap_s;
                end else begin
                    err_s    = 1'b1;
                    fault_s  = 1'b1;
                    errc_s   = (errc_s == ERR_MAX) ? errc_s : errc_s + ERR_ONE;
                    locked_s = 1'b0;
                    good_s   = 8'd0;
                    state_s  = valid_s ? ACQ : HUNT;
                end
            end
            default: begin
                state_s  = HUNT;
                locked_s = 1'b0;
                good_s   = 8'd0;
            end
        endcase
    end

    // State, sample history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= HUNT;
            prev_r   <= {LED_NUM{1'b0}};
            good_r   <= 8'd0;
            locked_r <= 1'b0;
            pos_r    <= {POS_W{1'b0}};
            lap_r    <= {LAP_W{1'b0}};
            err_r    <= 1'b0;
            fault_r  <= 1'b0;
            errc_r   <= {ERR_W{1'b0}};
        end else begin
            state_r  <= state_s;
            prev_r   <= bus.led_in;
            good_r   <= good_s;
            locked_r <= locked_s;
            pos_r    <= pos_s;
            lap_r    <= lap_s;
            err_r    <= err_s;
            fault_r  <= fault_s;
            errc_r   <= errc_s;
        end
    end
endmodule

// File: tb/tb_flow_led_monitor.sv
// tb_flow_led_monitor: directed vectors against an index-arithmetic ring model plus literal expectations.
module tb_flow_led_monitor;
    localparam int N    = 4;
    localparam int LOCK = 3;
`ifdef FLOW_LED_MON_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    bit   clk;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;
    bit   chk_en   = 1'b0;

    // model state: run = advances seen since the current valid anchor, -1 when no anchor
    logic [3:0] m_prev;
    bit         m_locked;
    int         m_run;
    int         m_pos;
    int         m_lap;
    bit         m_err;
    bit         m_fault;
    int         m_cnt;

    flow_led_if #(.LED_NUM(N), .LAP_W(16), .ERR_W(8)) bus ();

    flow_led_monitor #(.LED_NUM(N), .LOCK_CYCLES(LOCK), .LAP_W(16), .ERR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int idx(input logic [3:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic void model_reset();
        m_prev = 4'd0; m_locked = 1'b0; m_run = -1; m_pos = 0;
        m_lap = 0; m_err = 1'b0; m_fault = 1'b0; m_cnt = 0;
    endfunction

    function automatic void model_step(input logic [3:0] v, input logic c);
        bit valid, adv, stall;
        valid = ($countones(v) == 1);
        adv   = valid && ($countones(m_prev) == 1) && (idx(v) == (idx(m_prev) + 1) % N);
        stall = STALL && valid && (v == m_prev) && (m_locked || m_run >= 0);
        m_err = 1'b0;
        if (c) begin m_fault = 1'b0; m_cnt = 0; m_lap = 0; end
        if (m_locked) begin
            if (stall) begin
            end else if (adv) begin
                m_pos = idx(v);
                if (m_pos == 0) m_lap = (m_lap + 1) % 65536;
            end else begin
                m_err = 1'b1; m_fault = 1'b1;
                if (m_cnt < 255) m_cnt++;
                m_locked = 1'b0;
                m_run = valid ? 0 : -1;
            end
        end else if (m_run < 0) begin
            if (valid) m_run = 0;
        end else if (stall) begin
        end else if (adv) begin
            m_run++;
            if (m_run == LOCK) begin m_locked = 1'b1; m_pos = idx(v); end
        end else begin
            m_run = valid ? 0 : -1;
        end
        m_prev = v;
    endfunction

    task automatic step(input logic [3:0] v, input logic c = 1'b0, input logic r = 1'b0);
        bus.led_in  = v;
        bus.clr_err = c;
        rst         = r;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(v, c);
        @(negedge clk);
    endtask

    task automatic lock_seq();
        step(4'b0001); step(4'b0010); step(4'b0100); step(4'b1000);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("locked", {31'd0, bus.locked}, {31'd0, m_locked});
            check("pos", {30'd0, bus.pos}, m_pos);
            check("lap", {16'd0, bus.lap}, m_lap);
            check("err", {31'd0, bus.err}, {31'd0, m_err});
            check("fault", {31'd0, bus.fault}, {31'd0, m_fault});
            check("err_count", {24'd0, bus.err_count}, m_cnt);
        end
    end

    initial begin
        rst = 1'b1; bus.led_in = 4'd0; bus.clr_err = 1'b0;
        model_reset();
        step(4'b0000, 1'b0, 1'b1);
        chk_en = 1'b1;
        check("rst_locked", {31'd0, bus.locked}, 32'd0);
        check("rst_count", {24'd0, bus.err_count}, 32'd0);

        // 1: basic lock and first lap
        step(4'b0001); step(4'b0010); step(4'b0100);
        check("t1_not_yet", {31'd0, bus.locked}, 32'd0);
        step(4'b1000);
        check("t1_locked", {31'd0, bus.locked}, 32'd1);
        check("t1_pos3", {30'd0, bus.pos}, 32'd3);
        step(4'b0001);
        check("t1_pos0", {30'd0, bus.pos}, 32'd0);
        check("t1_lap1", {16'd0, bus.lap}, 32'd1);

        // 2: skip violation then relock
        step(4'b0010);
        step(4'b1000);
        check("t2_err", {31'd0, bus.err}, 32'd1);
        check("t2_fault", {31'd0, bus.fault}, 32'd1);
        check("t2_count", {24'd0, bus.err_count}, 32'd1);
        check("t2_unlock", {31'd0, bus.locked}, 32'd0);
        step(4'b0001);
        check("t2_err_once", {31'd0, bus.err}, 32'd0);
        step(4'b0010); step(4'b0100);
        check("t2_relock", {31'd0, bus.locked}, 32'd1);
        check("t2_pos2", {30'd0, bus.pos}, 32'd2);

        // 3: multi-hot violation then idle bus
        step(4'b1000);
        step(4'b0011);
        check("t3_err", {31'd0, bus.err}, 32'd1);
        for (int i = 0; i < 5; i++) step(4'b0000);
        check("t3_idle_count", {24'd0, bus.err_count}, 32'd2);
        check("t3_idle_lock", {31'd0, bus.locked}, 32'd0);

        // 4: saturation and clear-vs-violation priority
        step(4'b0000, 1'b1);
        check("t4_clr", {24'd0, bus.err_count}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            lock_seq();
            step(4'b0000);
            if (i == 254) check("t4_255", {24'd0, bus.err_count}, 32'd255);
        end
        check("t4_sat_err", {31'd0, bus.err}, 32'd1);
        check("t4_sat_hold", {24'd0, bus.err_count}, 32'd255);
        lock_seq();
        step(4'b0000, 1'b1);
        check("t4_clr_fault", {31'd0, bus.fault}, 32'd1);
        check("t4_clr_count", {24'd0, bus.err_count}, 32'd1);

        // 5: reset mid-rotation
        lock_seq();
        for (int k = 0; k < 7; k++) lock_seq();
        check("t5_lap7", {16'd0, bus.lap}, 32'd7);
        step(4'b0001, 1'b0, 1'b1);
        check("t5_rst_lock", {31'd0, bus.locked}, 32'd0);
        check("t5_rst_lap", {16'd0, bus.lap}, 32'd0);
        check("t5_rst_fault", {31'd0, bus.fault}, 32'd0);
        check("t5_rst_pos", {30'd0, bus.pos}, 32'd0);
        step(4'b0001); step(4'b0010); step(4'b0100);
        check("t5_three", {31'd0, bus.locked}, 32'd0);
        step(4'b1000);
        check("t5_four", {31'd0, bus.locked}, 32'd1);

        // 6: stalled rotation
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0001); step(4'b0010); step(4'b0010); step(4'b0100); step(4'b1000);
        check("t6_lock_after_1000", {31'd0, bus.locked}, {31'd0, STALL});
        step(4'b1000); step(4'b0001);
        check("t6_final_lock", {31'd0, bus.locked}, {31'd0, STALL});
        check("t6_no_err", {24'd0, bus.err_count}, 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
